obstacle_field_control: RTL and testbench

- Multi-slot successor to the single-obstacle mover. Manages NUM_OBS independent falling obstacles.
- Adds LFSR-randomised spawn X, timed spawning and a speed that ramps with obstacles passed.
- Sits between the game clock generator (game_en) and the renderer/collision detector. Exports packed position vectors, per-slot active flags and a pass counter for the score logic.

---
 rtl/obstacle_field_control.sv | 196 +++++++++++++++++++
 tb/tb_obstacle_field_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field_control.sv
// Multi-slot falling obstacle field: LFSR spawn X, timed spawns, speed ramp.
// Define OBS_DRIFT_EN to add a bouncing 1 px/tick horizontal drift.
module obstacle_field_control #(
  parameter int          NUM_OBS           = 4,
  parameter int          OBS_WIDTH         = 30,
  parameter int          OBS_HEIGHT        = 30,
  parameter int          SCREEN_W          = 640,
  parameter int          SCREEN_H          = 480,
  parameter int          BASE_SPEED        = 4,
  parameter int          MAX_SPEED         = 16,
  parameter int          SPEED_STEP_PASSES = 8,
  parameter int          SPAWN_GAP         = 20,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_en,
  input  logic                 clear,
  output logic [10*NUM_OBS-1:0] obs_x_pos,
  output logic [10*NUM_OBS-1:0] obs_y_pos,
  output logic [NUM_OBS-1:0]   obs_active,
  output logic [9:0]           obs_width,
  output logic [9:0]           obs_height,
  output logic [9:0]           cur_speed,
  output logic                 pass_pulse,
  output logic [15:0]          pass_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } state_e;

  localparam int CW = $clog2(SPAWN_GAP) + 1;

  localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - OBS_WIDTH);
  localparam logic [10:0]   Y_LIM    = 11'(SCREEN_H - OBS_HEIGHT);
  localparam logic [CW-1:0] GAP_LAST = CW'(SPAWN_GAP - 1);
  localparam logic [9:0]    SPD_BASE = 10'(BASE_SPEED);
  localparam logic [9:0]    SPD_MAX  = 10'(MAX_SPEED);
  localparam logic [15:0]   STEP_N   = 16'(SPEED_STEP_PASSES);

  state_e        st [NUM_OBS];
  logic [9:0]    x  [NUM_OBS];
  logic [9:0]    y  [NUM_OBS];
`ifdef OBS_DRIFT_EN
  logic          dir [NUM_OBS];
`endif

  logic [CW-1:0] spawn_cnt;
  logic [15:0]   step_cnt;
  logic [15:0]   lfsr;

  logic [10:0]        nxt_y [NUM_OBS];
  logic [NUM_OBS-1:0] passing;
  logic [NUM_OBS-1:0] spawn_sel;
  logic [3:0]         npass;
  logic               spawn_go;
  logic               lfsr_fb;
  logic [9:0]         raw_x;
  logic [9:0]         spawn_x;
  logic [16:0]        cnt_sum;
  logic [15:0]        step_sum;

  always_comb begin
    passing   = '0;
    npass     = '0;
    spawn_sel = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      nxt_y[i] = {1'b0, y[i]} + {1'b0, cur_speed};
      if (st[i] == FALL && nxt_y[i] > Y_LIM) begin
        passing[i] = 1'b1;
        npass      = npass + 4'd1;
      end
    end
    // Reverse scan so the lowest-index idle slot is the one left selected
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (st[i] == IDLE) begin
        spawn_sel    = '0;
        spawn_sel[i] = 1'b1;
      end
    end
  end

  assign spawn_go = (spawn_cnt == GAP_LAST) && (|spawn_sel);
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign raw_x    = lfsr[9:0];
  assign spawn_x  = (raw_x > X_MAX) ? raw_x - X_MAX - 10'd1 : raw_x;
  assign cnt_sum  = {1'b0, pass_count} + {13'd0, npass};
  assign step_sum = step_cnt + {12'd0, npass};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        st[i] <= IDLE;
        x[i]  <= '0;
        y[i]  <= '0;
`ifdef OBS_DRIFT_EN
        dir[i] <= 1'b0;
`endif
      end
      spawn_cnt  <= '0;
      step_cnt   <= '0;
      lfsr       <= LFSR_SEED;
      cur_speed  <= SPD_BASE;
      pass_count <= '0;
      pass_pulse <= 1'b0;
    end else if (clear) begin
      // Restart the field but keep the LFSR so the next game differs
      for (int i = 0; i < NUM_OBS; i++) begin
        st[i] <= IDLE;
        x[i]  <= '0;
        y[i]  <= '0;
`ifdef OBS_DRIFT_EN
        dir[i] <= 1'b0;
`endif
      end
      spawn_cnt  <= '0;
      step_cnt   <= '0;
      cur_speed  <= SPD_BASE;
      pass_count <= '0;
      pass_pulse <= 1'b0;
    end else begin
      pass_pulse <= 1'b0;
      if (game_en) begin
        lfsr       <= {lfsr[14:0], lfsr_fb};
        pass_pulse <= |passing;
        pass_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

        if (step_sum >= STEP_N) begin
          step_cnt <= step_sum - STEP_N;
          if (cur_speed < SPD_MAX)
            cur_speed <= cur_speed + 10'd1;
        end else begin
          step_cnt <= step_sum;
        end

        if (spawn_cnt != GAP_LAST)
          spawn_cnt <= spawn_cnt + CW'(1);
        else if (spawn_go)
          spawn_cnt <= '0;

        for (int i = 0; i < NUM_OBS; i++) begin
          unique case (st[i])
            IDLE: begin
              if (spawn_go && spawn_sel[i]) begin
                st[i] <= FALL;
                y[i]  <= '0;
                x[i]  <= spawn_x;
`ifdef OBS_DRIFT_EN
                dir[i] <= lfsr[10];
`endif
              end
            end
            FALL: begin
              if (passing[i]) begin
                st[i] <= IDLE;
                y[i]  <= '0;
              end else begin
                y[i] <= nxt_y[i][9:0];
`ifdef OBS_DRIFT_EN
                if (dir[i]) begin
                  if (x[i] == X_MAX)
                    dir[i] <= 1'b0;
                  else
                    x[i] <= x[i] + 10'd1;
                end else begin
                  if (x[i] == 10'd0)
                    dir[i] <= 1'b1;
                  else
                    x[i] <= x[i] - 10'd1;
                end
`endif
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    obs_x_pos  = '0;
    obs_y_pos  = '0;
    obs_active = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_x_pos[10*i +: 10] = x[i];
      obs_y_pos[10*i +: 10] = y[i];
      obs_active[i]         = (st[i] == FALL);
    end
  end

  assign obs_width  = 10'(OBS_WIDTH);
  assign obs_height = 10'(OBS_HEIGHT);

endmodule

// File: tb/tb_obstacle_field_control.sv
// Directed bench for obstacle_field_control across four parameter sets.
module tb_obstacle_field_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_en = 1'b0;
  logic clear = 1'b0;

  always #10 clk = ~clk;

  logic [39:0] a_x, a_y;
  logic [3:0]  a_act;
  logic [9:0]  a_w, a_h, a_spd;
  logic        a_pp;
  logic [15:0] a_pc;

  logic [9:0]  b_x, b_y;
  logic [0:0]  b_act;
  logic [9:0]  b_w, b_h, b_spd;
  logic        b_pp;
  logic [15:0] b_pc;

  logic [19:0] c_x, c_y;
  logic [1:0]  c_act;
  logic [9:0]  c_w, c_h, c_spd;
  logic        c_pp;
  logic [15:0] c_pc;

  logic [29:0] d_x, d_y;
  logic [2:0]  d_act;
  logic [9:0]  d_w, d_h, d_spd;
  logic        d_pp;
  logic [15:0] d_pc;

  obstacle_field_control u_a (
    .clk(clk), .rst(rst), .game_en(game_en), .clear(clear),
    .obs_x_pos(a_x), .obs_y_pos(a_y), .obs_active(a_act),
    .obs_width(a_w), .obs_height(a_h), .cur_speed(a_spd),
    .pass_pulse(a_pp), .pass_count(a_pc)
  );

  obstacle_field_control #(.NUM_OBS(1), .SPAWN_GAP(2)) u_b (
    .clk(clk), .rst(rst), .game_en(game_en), .clear(clear),
    .obs_x_pos(b_x), .obs_y_pos(b_y), .obs_active(b_act),
    .obs_width(b_w), .obs_height(b_h), .cur_speed(b_spd),
    .pass_pulse(b_pp), .pass_count(b_pc)
  );

  obstacle_field_control #(.NUM_OBS(2)) u_c (
    .clk(clk), .rst(rst), .game_en(game_en), .clear(clear),
    .obs_x_pos(c_x), .obs_y_pos(c_y), .obs_active(c_act),
    .obs_width(c_w), .obs_height(c_h), .cur_speed(c_spd),
    .pass_pulse(c_pp), .pass_count(c_pc)
  );

  obstacle_field_control #(
    .NUM_OBS(3), .SPAWN_GAP(1), .BASE_SPEED(1),
    .SPEED_STEP_PASSES(1), .OBS_HEIGHT(477)
  ) u_d (
    .clk(clk), .rst(rst), .game_en(game_en), .clear(clear),
    .obs_x_pos(d_x), .obs_y_pos(d_y), .obs_active(d_act),
    .obs_width(d_w), .obs_height(d_h), .cur_speed(d_spd),
    .pass_pulse(d_pp), .pass_count(d_pc)
  );

  int total = 0;
  int bad = 0;
  int t_n = 0;
  logic [15:0] lfsr_m;
  logic [9:0]  ex;
  logic [9:0]  x0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [9:0] fold(input logic [15:0] l);
    logic [9:0] r;
    r = l[9:0];
    return (r > 10'd610) ? r - 10'd611 : r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    game_en = 1'b1;
    @(posedge clk);
    #1;
    game_en = 1'b0;
    lfsr_m = lfsr_step(lfsr_m);
    t_n++;
  endtask

  task automatic tick_to(input int n);
    while (t_n < n) tick();
  endtask

  task automatic ramp_to(input logic [15:0] n);
    int guard;
    guard = 0;
    while (b_pc < n && guard < 30000) begin
      tick();
      guard++;
    end
    chk("ramp_count", b_pc, n);
  endtask

  initial begin
    lfsr_m = 16'hACE1;
    #35;
    chk("rst_act", a_act, 0);
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_speed", a_spd, 4);
    chk("rst_count", a_pc, 0);
    chk("rst_pulse", a_pp, 0);
    chk("width", a_w, 30);
    chk("height", a_h, 30);
    @(negedge clk);
    rst = 1'b0;

    tick_to(4);
    chk("d_count_t4", d_pc, 0);
    tick();
    chk("d_count_t5", d_pc, 1);
    chk("d_speed_t5", d_spd, 2);
    tick();
    chk("d_dual_count", d_pc, 3);
    chk("d_dual_pulse", d_pp, 1);
    chk("d_speed_t6", d_spd, 3);
    chk("d_act_t6", d_act, 3'b001);

    tick_to(19);
    chk("a_act_t19", a_act, 0);
    ex = fold(lfsr_m);
    tick();
    chk("a_act_t20", a_act, 4'b0001);
    chk("a_x0_spawn", a_x[9:0], ex);
    chk("a_y0_spawn", a_y[9:0], 0);
    x0 = ex;
    tick();
    chk("a_y0_t21", a_y[9:0], 4);

    tick_to(39);
    ex = fold(lfsr_m);
    tick();
    chk("a_act_t40", a_act, 4'b0011);
    chk("a_y0_t40", a_y[9:0], 80);
    chk("a_x1_spawn", a_x[19:10], ex);
`ifndef OBS_DRIFT_EN
    chk("a_x0_const", a_x[9:0], x0);
`else
    chk("a_x0_range", a_x[9:0] <= 10'd610, 1);
`endif

    tick_to(60);
    chk("c_act_t60", c_act, 2'b11);

    tick_to(114);
    chk("b_y_448", b_y, 448);
    chk("b_act_t114", b_act, 1);
    tick();
    chk("b_act_pass", b_act, 0);
    chk("b_y_pass", b_y, 0);
    chk("b_pulse_on", b_pp, 1);
    chk("b_count_1", b_pc, 1);
    @(posedge clk);
    #1;
    chk("b_pulse_off", b_pp, 0);
    tick();
    chk("b_act_respawn", b_act, 1);

    tick_to(132);
    chk("c_act_t132", c_act, 2'b11);
    tick();
    chk("c_act_t133", c_act, 2'b10);
    chk("c_count_t133", c_pc, 1);
    chk("a_count_t133", a_pc, 1);
    tick();
    chk("c_act_t134", c_act, 2'b11);
    chk("c_y0_t134", c_y[9:0], 0);

    @(negedge clk);
    clear = 1'b1;
    game_en = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    game_en = 1'b0;
    chk("clr_act", a_act, 0);
    chk("clr_x", a_x, 0);
    chk("clr_y", a_y, 0);
    chk("clr_speed", a_spd, 4);
    chk("clr_count", a_pc, 0);
    chk("clr_pulse", a_pp, 0);
    chk("clr_b_count", b_pc, 0);
    t_n = 0;
    tick_to(19);
    chk("clr_act_t19", a_act, 0);
    ex = fold(lfsr_m);
    tick();
    chk("clr_act_t20", a_act, 4'b0001);
    chk("clr_x_noreseed", a_x[9:0], ex);

    ramp_to(16'd8);
    chk("speed_8", b_spd, 5);
    ramp_to(16'd95);
    chk("speed_95", b_spd, 15);
    ramp_to(16'd96);
    chk("speed_96", b_spd, 16);
    ramp_to(16'd104);
    chk("speed_sat", b_spd, 16);

    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_act", a_act, 0);
    chk("mid_rst_x", a_x, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_speed", b_spd, 4);
    chk("mid_rst_count", b_pc, 0);
    chk("mid_rst_pulse", a_pp, 0);
    #20;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
